// File: rtl/rect_fill_engine.sv
// rtl/rect_fill_engine.sv - rectangle-fill rasterizer driving the framebuffer write port
//
// Ports:
//   clk_i, reset_i                  clock, synchronous active-high reset
//   cmd_valid_i / cmd_ready_o       command handshake (ready only in IDLE)
//   cmd_x0_i, cmd_x1_i              corner x coordinates, any order
//   cmd_y0_i, cmd_y1_i              corner y coordinates, any order
//   cmd_index_i                     palette index to write
//   abort_i                         terminate the current fill
//   busy_o                          high in SETUP or FILL
//   done_o                          one-cycle pulse after a normal completion
//   fb_wr_x_o, fb_wr_y_o            framebuffer write coordinates
//   fb_wr_index_o, fb_wr_en_o       framebuffer write data and strobe
module rect_fill_engine #(
    parameter int RESOLUTION_X   = 400,
    parameter int RESOLUTION_Y   = 300,
    parameter int PALETTE_LENGTH = 256,
    localparam int XW = $clog2(RESOLUTION_X),
    localparam int YW = $clog2(RESOLUTION_Y),
    localparam int IW = $clog2(PALETTE_LENGTH)
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          cmd_valid_i,
    output logic          cmd_ready_o,
    input  logic [XW-1:0] cmd_x0_i,
    input  logic [XW-1:0] cmd_x1_i,
    input  logic [YW-1:0] cmd_y0_i,
    input  logic [YW-1:0] cmd_y1_i,
    input  logic [IW-1:0] cmd_index_i,
    input  logic          abort_i,
    output logic          busy_o,
    output logic          done_o,
    output logic [XW-1:0] fb_wr_x_o,
    output logic [YW-1:0] fb_wr_y_o,
    output logic [IW-1:0] fb_wr_index_o,
    output logic          fb_wr_en_o
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        FILL
    } state_t;

    localparam logic [XW-1:0] X_LAST = XW'(RESOLUTION_X - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(RESOLUTION_Y - 1);

    state_t state_q, state_d;

    // Captured command fields
    logic [XW-1:0] x0_q, x1_q;
    logic [YW-1:0] y0_q, y1_q;
    logic [IW-1:0] index_q;

    // Normalized bounds used while filling
    logic [XW-1:0] xmin_q, xmax_q;
    logic [YW-1:0] ymin_q, ymax_q;

    // Clamped and normalized bounds computed during SETUP
    logic [XW-1:0] x0_c, x1_c, xmin_c, xmax_c;
    logic [YW-1:0] y0_c, y1_c, ymin_c, ymax_c;

    // Next values of the registered outputs
    logic [XW-1:0] wr_x_d;
    logic [YW-1:0] wr_y_d;
    logic [IW-1:0] wr_index_d;
    logic          wr_en_d;
    logic          done_d;
    logic          load_cmd;
    logic          load_bounds;

    // Clamping compares against RESOLUTION-1 so power-of-two sizes do not
    // truncate the bound to zero.
    always_comb begin
        x0_c   = (x0_q > X_LAST) ? X_LAST : x0_q;
        x1_c   = (x1_q > X_LAST) ? X_LAST : x1_q;
        y0_c   = (y0_q > Y_LAST) ? Y_LAST : y0_q;
        y1_c   = (y1_q > Y_LAST) ? Y_LAST : y1_q;
        xmin_c = (x0_c < x1_c) ? x0_c : x1_c;
        xmax_c = (x0_c < x1_c) ? x1_c : x0_c;
        ymin_c = (y0_c < y1_c) ? y0_c : y1_c;
        ymax_c = (y0_c < y1_c) ? y1_c : y0_c;
    end

    // The write-coordinate outputs double as the raster cursor, so they hold
    // their last value naturally whenever no write is issued.
    always_comb begin
        state_d     = state_q;
        wr_x_d      = fb_wr_x_o;
        wr_y_d      = fb_wr_y_o;
        wr_index_d  = fb_wr_index_o;
        wr_en_d     = 1'b0;
        done_d      = 1'b0;
        load_cmd    = 1'b0;
        load_bounds = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_valid_i && cmd_ready_o) begin
                    state_d  = SETUP;
                    load_cmd = 1'b1;
                end
            end
            SETUP: begin
                if (abort_i) begin
                    state_d = IDLE;
                end else begin
                    state_d     = FILL;
                    load_bounds = 1'b1;
                    wr_x_d      = xmin_c;
                    wr_y_d      = ymin_c;
                    wr_index_d  = index_q;
                    wr_en_d     = 1'b1;
                end
            end
            FILL: begin
                if (abort_i) begin
                    state_d = IDLE;
                end else if ((fb_wr_x_o == xmax_q) && (fb_wr_y_o == ymax_q)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (fb_wr_x_o == xmax_q) begin
                    wr_x_d  = xmin_q;
                    wr_y_d  = fb_wr_y_o + YW'(1);
                    wr_en_d = 1'b1;
                end else begin
                    wr_x_d  = fb_wr_x_o + XW'(1);
                    wr_en_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cmd_ready_o   <= 1'b1;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            fb_wr_en_o    <= 1'b0;
            fb_wr_x_o     <= '0;
            fb_wr_y_o     <= '0;
            fb_wr_index_o <= '0;
        end else begin
            cmd_ready_o   <= (state_d == IDLE);
            busy_o        <= (state_d != IDLE);
            done_o        <= done_d;
            fb_wr_en_o    <= wr_en_d;
            fb_wr_x_o     <= wr_x_d;
            fb_wr_y_o     <= wr_y_d;
            fb_wr_index_o <= wr_index_d;
        end
    end

    // Command and bound registers carry no meaning outside a fill and need no reset
    always_ff @(posedge clk_i) begin
        if (load_cmd) begin
            x0_q    <= cmd_x0_i;
            x1_q    <= cmd_x1_i;
            y0_q    <= cmd_y0_i;
            y1_q    <= cmd_y1_i;
            index_q <= cmd_index_i;
        end
        if (load_bounds) begin
            xmin_q <= xmin_c;
            xmax_q <= xmax_c;
            ymin_q <= ymin_c;
            ymax_q <= ymax_c;
        end
    end

endmodule

// File: tb/tb_rect_fill_engine.sv
// tb/tb_rect_fill_engine.sv - self-checking bench for rect_fill_engine
module tb_rect_fill_engine;

    localparam int RX   = 400;
    localparam int RY   = 300;
    localparam int MAXC = 1024;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       abort = 1'b0;
    logic [8:0] cx0 = '0, cx1 = '0;
    logic [8:0] cy0 = '0, cy1 = '0;
    logic [7:0] cidx = '0;
    logic       cmd_ready, busy, done, wr_en;
    logic [8:0] wr_x;
    logic [8:0] wr_y;
    logic [7:0] wr_idx;

    always #5 clk = ~clk;

    rect_fill_engine dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready),
        .cmd_x0_i     (cx0),
        .cmd_x1_i     (cx1),
        .cmd_y0_i     (cy0),
        .cmd_y1_i     (cy1),
        .cmd_index_i  (cidx),
        .abort_i      (abort),
        .busy_o       (busy),
        .done_o       (done),
        .fb_wr_x_o    (wr_x),
        .fb_wr_y_o    (wr_y),
        .fb_wr_index_o(wr_idx),
        .fb_wr_en_o   (wr_en)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    bit started = 1'b0;
    int wr_cnt = 0;
    int done_cnt = 0;

    // Expected behaviour indexed by cycle (value seen after edge number cyc)
    bit exp_en[MAXC], exp_done[MAXC], exp_busy[MAXC], exp_rdy[MAXC], exp_rst[MAXC];
    int exp_x[MAXC], exp_y[MAXC], exp_i[MAXC];
    int last_x = 0, last_y = 0, last_i = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // A fill accepted at edge h: SETUP after h, pixels after h+1.., done after the last.
    function automatic void plan(input int h, input int x0, input int x1,
                                 input int y0, input int y1, input int idx);
        int xa, xb, ya, yb, xl, xh, yl, yh, k;
        xa = (x0 > RX - 1) ? RX - 1 : x0;
        xb = (x1 > RX - 1) ? RX - 1 : x1;
        ya = (y0 > RY - 1) ? RY - 1 : y0;
        yb = (y1 > RY - 1) ? RY - 1 : y1;
        xl = (xa < xb) ? xa : xb;
        xh = (xa < xb) ? xb : xa;
        yl = (ya < yb) ? ya : yb;
        yh = (ya < yb) ? yb : ya;
        if (h < MAXC) begin
            exp_busy[h] = 1'b1;
            exp_rdy[h]  = 1'b0;
        end
        k = h + 1;
        for (int y = yl; y <= yh; y++) begin
            for (int x = xl; x <= xh; x++) begin
                if (k < MAXC) begin
                    exp_en[k]   = 1'b1;
                    exp_x[k]    = x;
                    exp_y[k]    = y;
                    exp_i[k]    = idx;
                    exp_busy[k] = 1'b1;
                    exp_rdy[k]  = 1'b0;
                end
                k++;
            end
        end
        if (k < MAXC) exp_done[k] = 1'b1;
    endfunction

    // Everything from cycle a onward returns to idle (abort or reset)
    function automatic void cut(input int a);
        for (int c = a; c < MAXC; c++) begin
            exp_en[c]   = 1'b0;
            exp_done[c] = 1'b0;
            exp_busy[c] = 1'b0;
            exp_rdy[c]  = 1'b1;
        end
    endfunction

    always @(negedge clk) begin
        if (started && cyc < MAXC) begin
            if (exp_rst[cyc]) begin
                last_x = 0;
                last_y = 0;
                last_i = 0;
            end
            if (exp_en[cyc]) begin
                last_x = exp_x[cyc];
                last_y = exp_y[cyc];
                last_i = exp_i[cyc];
            end
            chk("wr_en", wr_en, exp_en[cyc]);
            chk("done", done, exp_done[cyc]);
            chk("busy", busy, exp_busy[cyc]);
            chk("cmd_ready", cmd_ready, exp_rdy[cyc]);
            chk("wr_x", wr_x, last_x);
            chk("wr_y", wr_y, last_y);
            chk("wr_index", wr_idx, last_i);
            if (wr_en) begin
                wr_cnt++;
                chk("in_range", (wr_x < RX && wr_y < RY) ? 1 : 0, 1);
            end
            if (done) done_cnt++;
        end
    end

    // Presents a command at a falling edge and returns at the falling edge
    // just before the accepting rising edge h.
    task automatic send(input int x0, input int x1, input int y0, input int y1,
                        input int idx, output int h);
        int n;
        n = 0;
        @(negedge clk);
        cx0 = x0[8:0];
        cx1 = x1[8:0];
        cy0 = y0[8:0];
        cy1 = y1[8:0];
        cidx = idx[7:0];
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) chk("handshake_timeout", 0, 1);
        h = cyc + 1;
        plan(h, x0, x1, y0, y1, idx);
    endtask

    task automatic drop();
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        int h, h2, w0, d0;
        int ex[6];
        int ey[6];
        ex = '{2, 3, 4, 2, 3, 4};
        ey = '{0, 0, 0, 1, 1, 1};
        for (int c = 0; c < MAXC; c++) begin
            exp_en[c] = 1'b0; exp_done[c] = 1'b0; exp_busy[c] = 1'b0;
            exp_rdy[c] = 1'b1; exp_rst[c] = 1'b0;
            exp_x[c] = 0; exp_y[c] = 0; exp_i[c] = 0;
        end

        repeat (3) @(negedge clk);
        reset = 1'b0;
        started = 1'b1;
        chk("reset_ready", cmd_ready, 1);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_en", wr_en, 0);
        chk("reset_xy", {wr_x, wr_y}, 0);

        // abort in IDLE is ignored
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("idle_abort_ready", cmd_ready, 1);

        // single pixel
        send(5, 5, 7, 7, 8'h3C, h);
        w0 = wr_cnt;
        drop();
        wait_cyc(h + 1);
        chk("single_x", wr_x, 5);
        chk("single_y", wr_y, 7);
        chk("single_idx", wr_idx, 8'h3C);
        chk("single_en", wr_en, 1);
        wait_cyc(h + 2);
        chk("single_done", done, 1);
        chk("single_count", wr_cnt - w0, 1);

        // swapped corners
        send(4, 2, 1, 0, 9, h);
        w0 = wr_cnt;
        drop();
        for (int i = 0; i < 6; i++) begin
            wait_cyc(h + 1 + i);
            chk("swap_x", wr_x, ex[i]);
            chk("swap_y", wr_y, ey[i]);
        end
        wait_cyc(h + 7);
        chk("swap_done", done, 1);
        chk("swap_count", wr_cnt - w0, 6);

        // clipping
        send(398, 500, 298, 511, 7, h);
        w0 = wr_cnt;
        drop();
        wait_cyc(h + 4);
        chk("clip_last_x", wr_x, 399);
        chk("clip_last_y", wr_y, 299);
        wait_cyc(h + 6);
        chk("clip_count", wr_cnt - w0, 4);

        // back-to-back: second command held valid while the first runs
        send(10, 11, 20, 20, 1, h);
        send(0, 0, 0, 2, 2, h2);
        drop();
        chk("b2b_spacing", h2 - h, 4);
        wait_cyc(h2 + 1);
        chk("b2b_first_en", wr_en, 1);
        chk("b2b_first_idx", wr_idx, 2);
        wait_cyc(h2 + 4);
        chk("b2b_done", done, 1);

        // abort after the 15th write of a 10x10 fill
        send(0, 9, 0, 9, 8'h55, h);
        w0 = wr_cnt;
        d0 = done_cnt;
        drop();
        wait_cyc(h + 15);
        abort = 1'b1;
        cut(h + 16);
        @(negedge clk);
        abort = 1'b0;
        chk("abort_ready", cmd_ready, 1);
        chk("abort_en", wr_en, 0);
        wait_cyc(h + 30);
        chk("abort_count", wr_cnt - w0, 15);
        chk("abort_no_done", done_cnt - d0, 0);

        // abort while in SETUP
        send(3, 6, 3, 6, 8'h11, h);
        w0 = wr_cnt;
        drop();
        abort = 1'b1;
        cut(h + 1);
        @(negedge clk);
        abort = 1'b0;
        wait_cyc(h + 5);
        chk("setup_abort_count", wr_cnt - w0, 0);

        // reset mid-fill, then a normal fill
        send(0, 9, 0, 9, 8'h21, h);
        drop();
        wait_cyc(h + 20);
        reset = 1'b1;
        exp_rst[h + 21] = 1'b1;
        cut(h + 21);
        @(negedge clk);
        reset = 1'b0;
        chk("rst_en", wr_en, 0);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_x", wr_x, 0);
        chk("rst_y", wr_y, 0);
        chk("rst_idx", wr_idx, 0);
        send(1, 3, 2, 3, 4, h);
        w0 = wr_cnt;
        drop();
        wait_cyc(h + 7);
        chk("post_rst_done", done, 1);
        chk("post_rst_count", wr_cnt - w0, 6);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
